// File: rtl/axi_wid_fifo_gen_if.sv
// AW/W handshake bundle between the BIU master, the WID generator and the AXI3 pad side.
// The slave modport is the generator's view; the master modport is the BIU/pad driver's view.
interface axi_wid_fifo_gen_if #(
  parameter int ID_W = 8
);
  logic [ID_W-1:0] biu_pad_awid;
  logic            biu_pad_awvalid;
  logic            pad_biu_awready;
  logic            biu_awvalid_gated;
  logic            biu_awready_gated;
  logic            biu_pad_wvalid;
  logic            biu_pad_wlast;
  logic            pad_biu_wready;
  logic            biu_wvalid_gated;
  logic            biu_wready_gated;
  logic [ID_W-1:0] biu_pad_wid;

  modport slave (
    input  biu_pad_awid, biu_pad_awvalid, pad_biu_awready,
    input  biu_pad_wvalid, biu_pad_wlast, pad_biu_wready,
    output biu_awvalid_gated, biu_awready_gated,
    output biu_wvalid_gated, biu_wready_gated, biu_pad_wid
  );

  modport master (
    output biu_pad_awid, biu_pad_awvalid, pad_biu_awready,
    output biu_pad_wvalid, biu_pad_wlast, pad_biu_wready,
    input  biu_awvalid_gated, biu_awready_gated,
    input  biu_wvalid_gated, biu_wready_gated, biu_pad_wid
  );
endinterface

// File: rtl/axi_wid_fifo_gen.sv
// In-order AWID FIFO that supplies the AXI3 WID for AXI4-style W traffic and gates AW/W handshakes.
// Optional macro WID_FIFO_BYPASS_EN lets a W beat complete in the same cycle as its AW when empty.
module axi_wid_fifo_gen #(
  parameter  int ID_W  = 8,
  parameter  int DEPTH = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             per_clk,
  input  logic             pad_cpu_rst_b,
  axi_wid_fifo_gen_if.slave bus,
  input  logic             wid_hwm_clr,
  output logic [PTR_W:0]   wid_fifo_cnt,
  output logic             wid_fifo_full,
  output logic             wid_fifo_empty,
  output logic [PTR_W:0]   wid_fifo_hwm
);

  logic [PTR_W:0]  wptr_r;
  logic [PTR_W:0]  rptr_r;
  logic [PTR_W:0]  hwm_r;
  logic [ID_W-1:0] mem_r [DEPTH];

  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic            open_s;
  logic [ID_W-1:0] head_id_s;
  logic [PTR_W:0]  cnt_s;
  logic [PTR_W:0]  cnt_nxt_s;

  // Occupancy flags, handshake qualification and head-of-queue selection.
  always_comb begin
    full_s  = (wptr_r[PTR_W-1:0] == rptr_r[PTR_W-1:0]) && (wptr_r[PTR_W] != rptr_r[PTR_W]);
    empty_s = (wptr_r == rptr_r);
    push_s  = bus.biu_pad_awvalid & bus.pad_biu_awready & ~full_s;
`ifdef WID_FIFO_BYPASS_EN
    // An empty queue forwards the incoming AWID straight to the W side.
    open_s    = ~empty_s | push_s;
    head_id_s = empty_s ? bus.biu_pad_awid : mem_r[rptr_r[PTR_W-1:0]];
`else
    open_s    = ~empty_s;
    head_id_s = mem_r[rptr_r[PTR_W-1:0]];
`endif
    pop_s     = bus.biu_pad_wvalid & bus.pad_biu_wready & bus.biu_pad_wlast & open_s;
    cnt_s     = wptr_r - rptr_r;
    cnt_nxt_s = cnt_s + (PTR_W+1)'(push_s) - (PTR_W+1)'(pop_s);
  end

  // Gated handshakes and WID presented to the pad side.
  always_comb begin
    bus.biu_awvalid_gated = bus.biu_pad_awvalid & ~full_s;
    bus.biu_awready_gated = bus.pad_biu_awready & ~full_s;
    bus.biu_wvalid_gated  = bus.biu_pad_wvalid & open_s;
    bus.biu_wready_gated  = bus.pad_biu_wready & open_s;
    bus.biu_pad_wid       = open_s ? head_id_s : {ID_W{1'b0}};
    wid_fifo_cnt          = cnt_s;
    wid_fifo_full         = full_s;
    wid_fifo_empty        = empty_s;
    wid_fifo_hwm          = hwm_r;
  end

  // Pointer and ID storage; wrap bit in the pointer MSB distinguishes full from empty.
  always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      wptr_r <= {(PTR_W+1){1'b0}};
      rptr_r <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {ID_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wptr_r[PTR_W-1:0]] <= bus.biu_pad_awid;
        wptr_r                   <= wptr_r + (PTR_W+1)'(1);
      end else begin
        wptr_r <= wptr_r;
      end
      if (pop_s) begin
        rptr_r <= rptr_r + (PTR_W+1)'(1);
      end else begin
        rptr_r <= rptr_r;
      end
    end
  end

  // High-water mark tracks next-cycle occupancy; a clear reloads it rather than zeroing it.
  always_ff @(posedge per_clk or negedge pad_cpu_rst_b) begin
    if (!pad_cpu_rst_b) begin
      hwm_r <= {(PTR_W+1){1'b0}};
    end else if (wid_hwm_clr) begin
      hwm_r <= cnt_nxt_s;
    end else if (cnt_nxt_s > hwm_r) begin
      hwm_r <= cnt_nxt_s;
    end else begin
      hwm_r <= hwm_r;
    end
  end

endmodule
